misr_param: RTL and testbench
=============================

// Module: misr_param
// PURPOSE
//  Parametrised multiple-input signature register for the BIST response path.
//  Compacts NIN circuit-under-test outputs per cycle into a WIDTH-bit signature,
//  using a programmable feedback polynomial and reseed value.
//  Adds a run/done FSM, a compaction-cycle counter, and an on-chip golden
//  compare with pass/fail flags, so the BIST controller needs only start/bist_end.
// PARAMETERS
//  WIDTH  21             signature length, bits (>=2)
//  NIN    3              parallel inputs compacted per cycle (1..WIDTH)
//  POLY   {WIDTH{1'b1}}  feedback tap mask; bit i=1 means s[i] feeds back
//  SEED   {WIDTH{1'b1}}  value loaded into the signature on start
//  CNT_W  16             width of the compaction-cycle counter
// PORTS
//  CLK          in   1      clock, all state on rising edge
//  RST          in   1      synchronous, active-high reset
//  start        in   1      reseed and begin compaction (1-cycle pulse)
//  en           in   1      e valid this cycle; compact only when en=1 in RUN
//  e            in   NIN    CUT responses
//  bist_end     in   1      last pattern applied; finish compaction
//  golden       in   WIDTH  expected signature, sampled on the RUN->DONE edge
//  sig          out  WIDTH  current signature register (direct register output)
//  sig_valid    out  1      1 while in DONE
//  pass         out  1      registered: final sig == golden
//  fail         out  1      registered: final sig != golden
//  cycle_count  out  CNT_W  number of compacted cycles, saturating
//  cnt_sat      out  1      sticky: cycle_count reached all-ones
//  busy         out  1      1 while in RUN
// BEHAVIOUR
//  Reset (RST=1 at edge, highest priority): state=IDLE, sig=SEED, cycle_count=0,
//   cnt_sat=0, sig_valid=0, pass=0, fail=0, busy=0.
//  Compaction step (Fibonacci, shift toward bit 0), with s=sig:
//   s'[i] = s[i+1] ^ d[i] for i<WIDTH-1;  s'[WIDTH-1] = ^(s & POLY) ^ d[WIDTH-1].
//   d[WIDTH-1-k] = e[k] for k<NIN; all other d bits are 0.
//  FSM: IDLE, RUN, DONE.
//   IDLE: sig holds. start=1 -> RUN; sig<=SEED, cycle_count<=0, cnt_sat<=0.
//   RUN: busy=1. en=1 -> one compaction step, cycle_count+1.
//    cycle_count saturates at all-ones and sets cnt_sat; sig still compacts.
//    bist_end=1 -> DONE. If en=1 on the same edge, that data is compacted first.
//    On this edge pass/fail load from the post-step sig vs golden.
//    start=1 in RUN (any bist_end) -> reseed, counter cleared, stay in RUN,
//     no data compacted that cycle.
//   DONE: sig, pass, fail, cycle_count frozen; sig_valid=1; en, e, bist_end ignored.
//    start=1 -> RUN with reseed; pass, fail, sig_valid clear on that edge.
//  Latency: sig_valid/pass/fail high on the cycle after bist_end is sampled.
//  Outside DONE, pass=fail=0. In DONE exactly one of pass/fail is 1.
//  en=0 in RUN: sig and cycle_count hold (pipeline stall).
//  bist_end or en in IDLE: ignored.
// TESTING
//  1 Reset: RST=1 mid-RUN -> next cycle sig=21'h1FFFFF, IDLE, all flags 0.
//  2 Single step, defaults: start; en=1, e=3'b001 with bist_end=1 ->
//    sig=21'h0FFFFF, cycle_count=1, sig_valid=1.
//  3 Bit mapping: start; en=1, e=3'b100, then bist_end ->
//    sig=21'h1BFFFF, cycle_count=1.
//  4 Golden compare: 1000 LFSR-driven cycles with en toggling 50%;
//    golden = model sig -> pass=1, fail=0.
//    Flip one e bit in one cycle -> fail=1.
//  5 Stall/restart: en=0 for 10 cycles -> sig and cycle_count unchanged.
//    start in RUN -> sig=SEED, count=0.
//    start in DONE -> flags clear next cycle.
//  6 Saturation: CNT_W=4, 20 enabled cycles -> cycle_count=4'hF, cnt_sat=1,
//    sig matches the model over all 20 steps.

Source files
------------

// File: rtl/misr_param.sv
// Parametrised MISR for the BIST response path: compacts NIN CUT outputs per cycle
// into a WIDTH-bit signature, then compares it on-chip against a golden value.
module misr_param #(
    parameter int              WIDTH = 21,
    parameter int              NIN   = 3,
    parameter logic [WIDTH-1:0] POLY  = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}},
    parameter int              CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             en,
    input  logic [NIN-1:0]   e,
    input  logic             bist_end,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] sig,
    output logic             sig_valid,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] cycle_count,
    output logic             cnt_sat,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] step_sig;
    logic [WIDTH-1:0] post_sig;
    logic [CNT_W-1:0] cnt_inc;

    // Fibonacci step shifting toward bit 0; e[0] lands on the feedback (MSB) bit.
    // post_sig is the signature after this edge's optional step, used for the golden compare.
    always_comb begin
        d = '0;
        for (int k = 0; k < NIN; k++) begin
            d[WIDTH-1-k] = e[k];
        end
        step_sig = {^(sig & POLY), sig[WIDTH-1:1]} ^ d;
        post_sig = en ? step_sig : sig;
        cnt_inc  = (&cycle_count) ? cycle_count : cycle_count + CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            sig         <= SEED;
            cycle_count <= '0;
            cnt_sat     <= 1'b0;
            sig_valid   <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= RUN;
                        sig         <= SEED;
                        cycle_count <= '0;
                        cnt_sat     <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    // A restart wins over both data and bist_end on the same edge.
                    if (start) begin
                        sig         <= SEED;
                        cycle_count <= '0;
                        cnt_sat     <= 1'b0;
                    end else begin
                        if (en) begin
                            sig         <= step_sig;
                            cycle_count <= cnt_inc;
                            if (&cnt_inc) begin
                                cnt_sat <= 1'b1;
                            end
                        end
                        if (bist_end) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            sig_valid <= 1'b1;
                            pass      <= (post_sig == golden);
                            fail      <= (post_sig != golden);
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state       <= RUN;
                        sig         <= SEED;
                        cycle_count <= '0;
                        cnt_sat     <= 1'b0;
                        sig_valid   <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_misr_param.sv
// Directed self-checking bench for misr_param: default instance plus a CNT_W=4
// instance sharing the same stimulus for the saturation checks.
module tb_misr_param;

    localparam logic [20:0] SEED_TB = 21'h1FFFFF;
    localparam logic [20:0] POLY_TB = 21'h1FFFFF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        en = 1'b0;
    logic [2:0]  e = 3'b000;
    logic        bist_end = 1'b0;
    logic [20:0] golden = '0;

    logic [20:0] sig, sig2;
    logic        sig_valid, sig_valid2, pass, pass2, fail, fail2;
    logic        cnt_sat, cnt_sat2, busy, busy2;
    logic [15:0] cycle_count;
    logic [3:0]  cycle_count2;

    int total = 0;
    int bad = 0;

    logic [20:0] model;
    int          mcnt;
    logic [15:0] lfsr;

    always #5 CLK = ~CLK;

    misr_param dut (
        .CLK(CLK), .RST(RST), .start(start), .en(en), .e(e), .bist_end(bist_end),
        .golden(golden), .sig(sig), .sig_valid(sig_valid), .pass(pass), .fail(fail),
        .cycle_count(cycle_count), .cnt_sat(cnt_sat), .busy(busy)
    );

    misr_param #(.CNT_W(4)) dutSat (
        .CLK(CLK), .RST(RST), .start(start), .en(en), .e(e), .bist_end(bist_end),
        .golden(golden), .sig(sig2), .sig_valid(sig_valid2), .pass(pass2), .fail(fail2),
        .cycle_count(cycle_count2), .cnt_sat(cnt_sat2), .busy(busy2)
    );

    // Reference compaction step written out bit by bit for the 21-bit, 3-input case.
    function automatic logic [20:0] misrStep(input logic [20:0] s, input logic [2:0] ev);
        logic [20:0] r;
        r = {^(s & POLY_TB), s[20:1]};
        r[20] = r[20] ^ ev[0];
        r[19] = r[19] ^ ev[1];
        r[18] = r[18] ^ ev[2];
        return r;
    endfunction

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic en_i, input logic [2:0] e_i, input logic be);
        start = st;
        en = en_i;
        e = e_i;
        bist_end = be;
        @(posedge CLK);
        #1;
        start = 1'b0;
        en = 1'b0;
        bist_end = 1'b0;
    endtask

    // Drives a 1000-cycle run; flipCycle >= 0 corrupts one e bit seen by the DUT only.
    task automatic longRun(input int flipCycle);
        logic        env;
        logic [2:0]  ev;
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        model = SEED_TB;
        mcnt = 0;
        lfsr = 16'hACE1;
        for (int i = 0; i < 1000; i++) begin
            lfsr = lfsrNext(lfsr);
            env = lfsr[7];
            ev = lfsr[2:0];
            if (i == flipCycle) env = 1'b1;
            if (env) begin
                model = misrStep(model, ev);
                mcnt++;
            end
            if (i == flipCycle) ev[1] = ~ev[1];
            if (i == 999) golden = model;
            applyStimulus(1'b0, env, ev, (i == 999));
        end
    endtask

    initial begin
        $display("[TB] starting misr_param bench");
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset state
        checkOutput("rst_sig", 32'(sig), 32'(SEED_TB));
        checkOutput("rst_cnt", 32'(cycle_count), 0);
        checkOutput("rst_flags", {28'd0, sig_valid, pass, fail, busy}, 0);

        // IDLE ignores en/bist_end
        applyStimulus(1'b0, 1'b1, 3'b111, 1'b1);
        checkOutput("idle_sig", 32'(sig), 32'(SEED_TB));
        checkOutput("idle_flags", {28'd0, sig_valid, pass, fail, busy}, 0);

        // Reset mid-RUN
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("run_busy", 32'(busy), 1);
        applyStimulus(1'b0, 1'b1, 3'b101, 1'b0);
        applyStimulus(1'b0, 1'b1, 3'b011, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("midrst_sig", 32'(sig), 32'h1FFFFF);
        checkOutput("midrst_cnt", 32'(cycle_count), 0);
        checkOutput("midrst_flags", {27'd0, cnt_sat, sig_valid, pass, fail, busy}, 0);

        // Single step with bist_end on the same edge
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        golden = 21'h0FFFFF;
        applyStimulus(1'b0, 1'b1, 3'b001, 1'b1);
        checkOutput("single_sig", 32'(sig), 32'h0FFFFF);
        checkOutput("single_cnt", 32'(cycle_count), 1);
        checkOutput("single_valid", {29'd0, sig_valid, busy, pass}, 32'b101);
        checkOutput("single_fail", 32'(fail), 0);

        // DONE freezes everything
        applyStimulus(1'b0, 1'b1, 3'b111, 1'b1);
        checkOutput("done_hold_sig", 32'(sig), 32'h0FFFFF);
        checkOutput("done_hold_cnt", 32'(cycle_count), 1);

        // Start in DONE clears flags; then bit-mapping check with a wrong golden
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("restart_flags", {28'd0, sig_valid, pass, fail, busy}, 32'b0001);
        checkOutput("restart_sig", 32'(sig), 32'(SEED_TB));
        golden = 21'h000000;
        applyStimulus(1'b0, 1'b1, 3'b100, 1'b0);
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkOutput("map_sig", 32'(sig), 32'h1BFFFF);
        checkOutput("map_cnt", 32'(cycle_count), 1);
        checkOutput("map_passfail", {30'd0, pass, fail}, 32'b01);

        // Long golden run, clean then with one corrupted input bit
        longRun(-1);
        checkOutput("long_sig", 32'(sig), 32'(model));
        checkOutput("long_cnt", 32'(cycle_count), 32'(mcnt));
        checkOutput("long_passfail", {30'd0, pass, fail}, 32'b10);
        longRun(500);
        checkOutput("flip_passfail", {30'd0, pass, fail}, 32'b01);

        // Stall, start-in-RUN reseed
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        model = SEED_TB;
        applyStimulus(1'b0, 1'b1, 3'b110, 1'b0);
        model = misrStep(model, 3'b110);
        applyStimulus(1'b0, 1'b1, 3'b011, 1'b0);
        model = misrStep(model, 3'b011);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 3'(i), 1'b0);
        end
        checkOutput("stall_sig", 32'(sig), 32'(model));
        checkOutput("stall_cnt", 32'(cycle_count), 2);
        applyStimulus(1'b1, 1'b1, 3'b111, 1'b1);
        checkOutput("runstart_sig", 32'(sig), 32'(SEED_TB));
        checkOutput("runstart_cnt", 32'(cycle_count), 0);
        checkOutput("runstart_busy", {30'd0, busy, sig_valid}, 32'b10);

        // Saturation on the 4-bit counter instance
        model = SEED_TB;
        lfsr = 16'h1234;
        for (int i = 1; i <= 20; i++) begin
            lfsr = lfsrNext(lfsr);
            model = misrStep(model, lfsr[2:0]);
            applyStimulus(1'b0, 1'b1, lfsr[2:0], 1'b0);
            if (i == 14) checkOutput("sat_pre", {27'd0, cnt_sat2, cycle_count2}, 32'h0E);
            if (i == 15) checkOutput("sat_hit", {27'd0, cnt_sat2, cycle_count2}, 32'h1F);
        end
        checkOutput("sat_end", {27'd0, cnt_sat2, cycle_count2}, 32'h1F);
        checkOutput("sat_sig", 32'(sig2), 32'(model));
        checkOutput("wide_cnt", {15'd0, cnt_sat, cycle_count}, 32'd20);
        golden = model;
        applyStimulus(1'b0, 1'b0, 3'b000, 1'b1);
        checkOutput("sat_pass", {29'd0, sig_valid2, pass2, fail2}, 32'b110);

        // Flags clear on the cycle after start in DONE
        applyStimulus(1'b1, 1'b0, 3'b000, 1'b0);
        checkOutput("done_start_flags", {28'd0, sig_valid, pass, fail, busy}, 32'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
